// File: rtl/asts_fare_engine.sv
// Multi-route ticket fare engine: credits nickel/dime/quarter strobes against a
// per-route fare, dispenses one ticket, and returns change or refunds as nickel pulses.
module asts_fare_engine #(
   parameter int NUM_ROUTES = 16,
   parameter int ROUTE_W    = 4,
   parameter int BASE_FARE  = 2,
   parameter int FARE_STEP  = 1,
   parameter int CREDIT_W   = 6
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [ROUTE_W-1:0]  route_number,
   input  logic                nickel_in,
   input  logic                dime_in,
   input  logic                quarter_in,
   input  logic                cancel,
   output logic                dispense,
   output logic                nickel_out,
   output logic                coin_reject,
   output logic                busy,
   output logic [CREDIT_W-1:0] credit,
   output logic [CREDIT_W-1:0] fare
);

   // state    | meaning
   // IDLE     | no transaction; fare tracks route_number
   // COLLECT  | route latched (held in fare), accumulating coins
   // DISPENSE | one-cycle ticket release, credit holds the change
   // CHANGE   | paying out change, one nickel per cycle
   // REFUND   | paying back cancelled credit, one nickel per cycle
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      COLLECT  = 3'd1,
      DISPENSE = 3'd2,
      CHANGE   = 3'd3,
      REFUND   = 3'd4
   } state_t;

   localparam logic [CREDIT_W-1:0] BASE_C      = CREDIT_W'(BASE_FARE);
   localparam logic [CREDIT_W-1:0] STEP_C      = CREDIT_W'(FARE_STEP);
   localparam logic [CREDIT_W-1:0] ONE_C       = CREDIT_W'(1);
   localparam logic [CREDIT_W:0]   CREDIT_MAX  = {1'b0, {CREDIT_W{1'b1}}};
   localparam logic [ROUTE_W:0]    ROUTE_LIMIT = (ROUTE_W+1)'(NUM_ROUTES);

   state_t              state;
   logic [1:0]          strobe_count;
   logic                one_coin;
   logic                any_coin;
   logic [CREDIT_W-1:0] coin_value;
   logic [CREDIT_W-1:0] fare_cur;
   logic [CREDIT_W-1:0] fare_sel;
   logic [CREDIT_W:0]   sum;
   logic [CREDIT_W-1:0] change;
   logic                route_ok;
   logic                room_ok;
   logic                accept;
   logic                completes;

   always_comb begin
      strobe_count = 2'(nickel_in) + 2'(dime_in) + 2'(quarter_in);
      one_coin     = (strobe_count == 2'd1);
      any_coin     = (strobe_count != 2'd0);

      coin_value = '0;
      if (nickel_in)       coin_value = CREDIT_W'(1);
      else if (dime_in)    coin_value = CREDIT_W'(2);
      else if (quarter_in) coin_value = CREDIT_W'(5);

      // The fare register doubles as the latched route once a transaction starts.
      fare_cur = BASE_C + CREDIT_W'(route_number) * STEP_C;
      fare_sel = (state == IDLE) ? fare_cur : fare;

      route_ok  = ({1'b0, route_number} < ROUTE_LIMIT);
      sum       = {1'b0, credit} + {1'b0, coin_value};
      room_ok   = (sum <= CREDIT_MAX);
      accept    = one_coin && !cancel && room_ok &&
                  (((state == IDLE) && route_ok) || (state == COLLECT));
      completes = (sum >= {1'b0, fare_sel});
      change    = sum[CREDIT_W-1:0] - fare_sel;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         credit      <= '0;
         fare        <= '0;
         dispense    <= 1'b0;
         nickel_out  <= 1'b0;
         coin_reject <= 1'b0;
         busy        <= 1'b0;
      end else begin
         dispense    <= 1'b0;
         nickel_out  <= 1'b0;
         coin_reject <= any_coin && !accept;

         unique case (state)
            IDLE: begin
               fare <= fare_cur;
               if (accept) begin
                  busy <= 1'b1;
                  if (completes) begin
                     credit   <= change;
                     dispense <= 1'b1;
                     state    <= DISPENSE;
                  end else begin
                     credit <= sum[CREDIT_W-1:0];
                     state  <= COLLECT;
                  end
               end
            end

            COLLECT: begin
               // Credit is at least one unit here, so the first refund nickel is due now.
               if (cancel) begin
                  nickel_out <= 1'b1;
                  credit     <= credit - ONE_C;
                  state      <= REFUND;
               end else if (accept) begin
                  if (completes) begin
                     credit   <= change;
                     dispense <= 1'b1;
                     state    <= DISPENSE;
                  end else begin
                     credit <= sum[CREDIT_W-1:0];
                  end
               end
            end

            DISPENSE, CHANGE, REFUND: begin
               if (credit == '0) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  nickel_out <= 1'b1;
                  credit     <= credit - ONE_C;
                  if (state == DISPENSE) state <= CHANGE;
               end
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
